isqrt_pipe_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined `isqrt` instance between `N_REQ` independent requesters. Each cycle it issues at most one granted argument into `isqrt` and records the requester id in a tag shift register aligned with the `isqrt` pipeline. It then routes each result back to the requester that issued it. It sits between several formula FSMs and the single `isqrt` instance in the top level. It replaces per-FSM private `isqrt` instances.

---
 rtl/isqrt_pipe_arbiter_if.sv | 21 ++
 rtl/isqrt_pipe_arbiter.sv | 131 +++++++++++++
 tb/tb_isqrt_pipe_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isqrt_pipe_arbiter_if.sv
// Requester-side bundle of isqrt_pipe_arbiter: argument handshake and result return.
// master = requester side, slave = arbiter side.
interface isqrt_pipe_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req_vld;
  logic [32*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    rsp_vld;
  logic [15:0]         rsp_y;

  modport master (
    output req_vld, req_x,
    input  req_rdy, rsp_vld, rsp_y
  );

  modport slave (
    input  req_vld, req_x,
    output req_rdy, rsp_vld, rsp_y
  );
endinterface

// File: rtl/isqrt_pipe_arbiter.sv
// Round-robin arbiter sharing one pipelined isqrt between N_REQ requesters.
// A tag pipe aligned with the isqrt latency routes each result to its issuer.
// Optional macro ISQRT_ARB_CHECK_EN: enables the sticky err flag for tag/result
// mismatch and in-flight counter underflow; otherwise err is tied low.
module isqrt_pipe_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ISQRT_LATENCY = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  isqrt_pipe_arbiter_if.slave        req_bus,
  output logic                       busy,
  output logic                       err,
  output logic                       isqrt_x_vld,
  output logic [31:0]                isqrt_x,
  input  logic                       isqrt_y_vld,
  input  logic [15:0]                isqrt_y
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(ISQRT_LATENCY + 1);
  localparam int unsigned L    = ISQRT_LATENCY;

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic            tag_vld_q [L];
  logic [IdW-1:0]  tag_id_q  [L];
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            gnt;
  logic [IdW-1:0]  gnt_id;
  logic [IdW-1:0]  cand_id;
  int unsigned     cand;
  logic            ret;
  logic [N_REQ-1:0] rdy;
  logic [N_REQ-1:0] rsp;

  // Grant search: first valid requester starting at ptr_q, wrapping at N_REQ
  always_comb begin
    gnt     = 1'b0;
    gnt_id  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_id = IdW'(cand);
      if (!gnt && req_bus.req_vld[cand_id]) begin
        gnt    = 1'b1;
        gnt_id = cand_id;
      end
    end
    // No issue may leave while the shared pipe is being reset
    if (rst) gnt = 1'b0;
  end

  // One-hot grant and argument mux to isqrt
  always_comb begin
    rdy     = '0;
    isqrt_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt && gnt_id == IdW'(i)) begin
        rdy[i]  = 1'b1;
        isqrt_x = req_bus.req_x[32*i +: 32];
      end
    end
  end

  assign req_bus.req_rdy = rdy;
  assign isqrt_x_vld     = gnt;

  // Result routing from the tag leaving the pipe
  assign ret = isqrt_y_vld & tag_vld_q[L-1];

  always_comb begin
    rsp = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp[i] = ret && !rst && (tag_id_q[L-1] == IdW'(i));
    end
  end

  assign req_bus.rsp_vld = rsp;
  assign req_bus.rsp_y   = isqrt_y;

  // Next pointer and in-flight count
  always_comb begin
    ptr_d = ptr_q;
    if (gnt) ptr_d = (gnt_id == IdW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    cnt_d = cnt_q + CntW'(gnt) - CntW'(ret);
  end

  assign busy = (cnt_q != '0);

  // Pointer, counter and tag pipe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= gnt;
      tag_id_q[0]  <= gnt_id;
      for (int unsigned i = 1; i < L; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

`ifdef ISQRT_ARB_CHECK_EN
  logic err_q;

  // Sticky error: result without matching tag (or vice versa), or counter underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((isqrt_y_vld != tag_vld_q[L-1]) || (ret && !gnt && cnt_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Self-checking bench for isqrt_pipe_arbiter with a behavioural isqrt pipeline.
module tb_isqrt_pipe_arbiter;

  localparam int N = 4;
  localparam int L = 16;
`ifdef ISQRT_ARB_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, err;
  logic        isqrt_x_vld, isqrt_y_vld;
  logic [31:0] isqrt_x;
  logic [15:0] isqrt_y;
  logic        inject;

  always #5 clk = ~clk;

  isqrt_pipe_arbiter_if #(.N_REQ(N)) bus ();

  isqrt_pipe_arbiter #(
    .N_REQ(N),
    .ISQRT_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_bus(bus),
    .busy(busy),
    .err(err),
    .isqrt_x_vld(isqrt_x_vld),
    .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld),
    .isqrt_y(isqrt_y)
  );

  function automatic logic [15:0] sqrt32(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({16'd0, t} * {16'd0, t} <= x) r = t;
    end
    return r;
  endfunction

  // Behavioural isqrt: fixed latency L, cleared by the same reset
  logic        m_vld [L];
  logic [15:0] m_y   [L];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) m_vld[i] <= 1'b0;
    end else begin
      m_vld[0] <= isqrt_x_vld;
      m_y[0]   <= sqrt32(isqrt_x);
      for (int i = 1; i < L; i++) begin
        m_vld[i] <= m_vld[i-1];
        m_y[i]   <= m_y[i-1];
      end
    end
  end

  assign isqrt_y_vld = m_vld[L-1] | inject;
  assign isqrt_y     = m_y[L-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected responses queued at issue time with their due cycle
  typedef struct {
    int          id;
    logic [15:0] y;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   gcnt[N] = '{default: 0};

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_vld[i] && bus.req_rdy[i]) begin
          sb.push_back('{id: i, y: sqrt32(bus.req_x[32*i +: 32]), due: cyc + L});
          gcnt[i]++;
        end
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rsp_vld", 64'(bus.rsp_vld), 64'(1) << e.id);
        chk("sb_rsp_y", 64'(bus.rsp_y), 64'(e.y));
      end else if (bus.rsp_vld != '0) begin
        chk("sb_rsp_unexpected", 64'(bus.rsp_vld), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] x);
    bus.req_vld[id]         = 1'b1;
    bus.req_x[32*id +: 32]  = x;
  endtask

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t vecs[8];
  int   g0[N];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{id: 0, x: 32'd144,        y: 16'd12};
    vecs[1] = '{id: 1, x: 32'd0,          y: 16'd0};
    vecs[2] = '{id: 2, x: 32'd1,          y: 16'd1};
    vecs[3] = '{id: 3, x: 32'd2,          y: 16'd1};
    vecs[4] = '{id: 0, x: 32'd15,         y: 16'd3};
    vecs[5] = '{id: 2, x: 32'd16,         y: 16'd4};
    vecs[6] = '{id: 1, x: 32'hFFFF_FFFF,  y: 16'hFFFF};
    vecs[7] = '{id: 3, x: 32'd1000000,    y: 16'd1000};

    bus.req_vld = '0;
    bus.req_x   = '0;
    inject      = 1'b0;
    rst         = 1'b1;

    // Reset: grants forced off even with every requester asking
    repeat (2) @(posedge clk);
    #1 bus.req_vld = '1;
    @(negedge clk);
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
    chk("rst_x_vld", 64'(isqrt_x_vld), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'(0));
    tick();
    rst         = 1'b0;
    bus.req_vld = '0;

    // Table: isolated single requests, latency and busy window
    for (int v = 0; v < 8; v++) begin
      tick();
      set_req(vecs[v].id, vecs[v].x);
      @(negedge clk);
      chk("vec_rdy", 64'(bus.req_rdy), 64'(1) << vecs[v].id);
      chk("vec_x", 64'(isqrt_x), 64'(vecs[v].x));
      chk("vec_busy_issue", 64'(busy), 64'(0));
      tick();
      bus.req_vld = '0;
      for (int k = 1; k <= L; k++) begin
        @(negedge clk);
        chk("vec_busy", 64'(busy), 64'(1));
        if (k == L) begin
          chk("vec_rsp_vld", 64'(bus.rsp_vld), 64'(1) << vecs[v].id);
          chk("vec_rsp_y", 64'(bus.rsp_y), 64'(vecs[v].y));
        end
      end
      @(negedge clk);
      chk("vec_busy_end", 64'(busy), 64'(0));
    end

    // Full contention from ptr=0 (last grant above went to requester 3)
    tick();
    for (int i = 0; i < N; i++) set_req(i, 32'((i + 1) * (i + 1)));
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("cont_gnt", 64'(bus.req_rdy), 64'(1) << k);
      tick();
      bus.req_vld[k] = 1'b0;
    end
    repeat (L + 2) @(negedge clk);
    chk("cont_busy_end", 64'(busy), 64'(0));

    // Fairness between requesters 1 and 3
    for (int i = 0; i < N; i++) g0[i] = gcnt[i];
    tick();
    set_req(1, 32'd25);
    set_req(3, 32'd49);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("fair_gnt", 64'(bus.req_rdy), (k % 2 == 0) ? 64'd2 : 64'd8);
      tick();
    end
    bus.req_vld = '0;
    for (int i = 0; i < N; i++) begin
      chk("fair_cnt", 64'(gcnt[i] - g0[i]), (i == 1 || i == 3) ? 64'd10 : 64'd0);
    end
    repeat (L + 2) @(negedge clk);

    // Streaming from requester 2, one issue per cycle
    tick();
    for (int k = 1; k <= 32; k++) begin
      set_req(2, 32'(k * k));
      @(negedge clk);
      chk("stream_gnt", 64'(bus.req_rdy), 64'd4);
      if (k > 1) chk("stream_busy", 64'(busy), 64'(1));
      tick();
    end
    bus.req_vld = '0;
    repeat (L + 2) @(negedge clk);
    chk("stream_busy_end", 64'(busy), 64'(0));

    // Reset while five requests are in flight; ptr left at 1 beforehand
    tick();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 32'(100 + k));
      @(negedge clk);
      chk("mid_gnt", 64'(bus.req_rdy), 64'd1);
      tick();
    end
    bus.req_vld = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(0));
    tick();
    set_req(0, 32'd81);
    set_req(3, 32'd64);
    @(negedge clk);
    chk("mid_ptr_gnt0", 64'(bus.req_rdy), 64'd1);
    tick();
    bus.req_vld[0] = 1'b0;
    @(negedge clk);
    chk("mid_ptr_gnt3", 64'(bus.req_rdy), 64'd8);
    tick();
    bus.req_vld = '0;
    repeat (L + 4) @(negedge clk);
    chk("mid_busy_end", 64'(busy), 64'(0));
    chk("err_clean", 64'(err), 64'(0));

    // Stray result with no tag
    tick();
    inject = 1'b1;
    @(negedge clk);
    chk("inj_rsp_vld", 64'(bus.rsp_vld), 64'(0));
    tick();
    inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("inj_err", 64'(err), 64'(ExpErr));
    repeat (5) @(negedge clk);
    chk("inj_err_hold", 64'(err), 64'(ExpErr));
    chk("inj_busy", 64'(busy), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("inj_err_rst", 64'(err), 64'(0));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
